hs_ioctl_master: RTL and testbench

Synthesizable initiator for the HPS ioctl byte-transfer protocol used by the hiscore block. It drives `ioctl_download`/`ioctl_upload`, `ioctl_index`, `ioctl_addr`, `ioctl_dout` and `ioctl_wr` exactly as the HPS does, and captures `ioctl_din` on uploads. Bytes come from a local synchronous byte source; uploaded bytes go to a byte sink. It sits in place of hps_io for standalone bring-up and for simulation of cores carrying the hiscore block.

---
 rtl/hs_ioctl_master.sv | 188 ++++++++++++++++++
 tb/tb_hs_ioctl_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hs_ioctl_master.sv
// hs_ioctl_master: HPS-style ioctl initiator that downloads bytes from a local source
// or uploads bytes from the core into a sink, with HPS setup/hold and pacing.
module hs_ioctl_master #(
    parameter int ADDR_WIDTH   = 25,
    parameter int LEN_WIDTH    = 16,
    parameter int SETUP_CYCLES = 2,
    parameter int WR_GAP       = 4,
    parameter int RD_WAIT      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_upload,
    input  logic [7:0]            cmd_index,
    input  logic [LEN_WIDTH-1:0]  cmd_length,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  src_addr,
    input  logic [7:0]            src_data,
    output logic                  snk_wr,
    output logic [LEN_WIDTH-1:0]  snk_addr,
    output logic [7:0]            snk_data,
    output logic                  ioctl_download,
    output logic                  ioctl_upload,
    output logic                  ioctl_wr,
    output logic [7:0]            ioctl_index,
    output logic [ADDR_WIDTH-1:0] ioctl_addr,
    output logic [7:0]            ioctl_dout,
    input  logic [7:0]            ioctl_din
);
    typedef enum logic [3:0] {
        IDLE, SETUP, FETCH, LATCH, WRITE, GAP, RADDR, RWAIT, CAPTURE, FINISH, DONE
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]  n_q, n_d, len_q, len_d, src_addr_q, src_addr_d, snk_addr_q, snk_addr_d;
    logic                  up_q, up_d, busy_q, busy_d, done_q, done_d, snk_wr_q, snk_wr_d;
    logic                  dl_q, dl_d, ul_q, ul_d, wr_q, wr_d;
    logic [7:0]            snk_data_q, snk_data_d, index_q, index_d, dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last, setup_end;

    assign last      = n_q == len_q - LEN_WIDTH'(1);
    assign setup_end = cnt_q == 16'(SETUP_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        n_d        = n_q;
        len_d      = len_q;
        up_d       = up_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        snk_wr_d   = 1'b0;
        snk_addr_d = snk_addr_q;
        snk_data_d = snk_data_q;
        dl_d       = dl_q;
        ul_d       = ul_q;
        wr_d       = 1'b0;
        index_d    = index_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_start) begin
                    state_d = SETUP;
                    up_d    = cmd_upload;
                    len_d   = cmd_length;
                    index_d = cmd_index;
                    n_d     = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    dl_d    = !cmd_upload;
                    ul_d    = cmd_upload;
                end
            end
            SETUP: begin
                if (setup_end) begin
                    cnt_d   = '0;
                    state_d = len_q == '0 ? FINISH : up_q ? RADDR : FETCH;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                dout_d  = src_data;
                addr_d  = ADDR_WIDTH'(n_q);
                state_d = WRITE;
            end
            // wr is registered, so the pulse lands one cycle after addr/dout settle
            WRITE: begin
                wr_d    = 1'b1;
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == 16'(WR_GAP - 1)) begin
                    cnt_d   = '0;
                    n_d     = n_q + LEN_WIDTH'(1);
                    state_d = last ? FINISH : FETCH;
                end
            end
            RADDR: begin
                addr_d  = ADDR_WIDTH'(n_q);
                cnt_d   = '0;
                state_d = RWAIT;
            end
            RWAIT: state_d = cnt_q == 16'(RD_WAIT - 1) ? CAPTURE : RWAIT;
            CAPTURE: begin
                snk_wr_d   = 1'b1;
                snk_data_d = ioctl_din;
                snk_addr_d = n_q;
                n_d        = n_q + LEN_WIDTH'(1);
                cnt_d      = '0;
                state_d    = last ? FINISH : RADDR;
            end
            // strobe held SETUP_CYCLES, then one low cycle for the receiver's index compare
            FINISH: begin
                if (setup_end) begin
                    dl_d = 1'b0;
                    ul_d = 1'b0;
                end
                if (cnt_q == 16'(SETUP_CYCLES)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        src_addr_d = n_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            len_q      <= '0;
            up_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_addr_q <= '0;
            snk_wr_q   <= 1'b0;
            snk_addr_q <= '0;
            snk_data_q <= '0;
            dl_q       <= 1'b0;
            ul_q       <= 1'b0;
            wr_q       <= 1'b0;
            index_q    <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            len_q      <= len_d;
            up_q       <= up_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            src_addr_q <= src_addr_d;
            snk_wr_q   <= snk_wr_d;
            snk_addr_q <= snk_addr_d;
            snk_data_q <= snk_data_d;
            dl_q       <= dl_d;
            ul_q       <= ul_d;
            wr_q       <= wr_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign src_addr       = src_addr_q;
    assign snk_wr         = snk_wr_q;
    assign snk_addr       = snk_addr_q;
    assign snk_data       = snk_data_q;
    assign ioctl_download = dl_q;
    assign ioctl_upload   = ul_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_index    = index_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;
endmodule

// File: tb/tb_hs_ioctl_master.sv
// tb_hs_ioctl_master: scoreboard bench for hs_ioctl_master with a byte-source model
// and a core model answering uploads with addr^0xA5 after three cycles.
module tb_hs_ioctl_master;
    localparam int SETUP   = 2;
    localparam int WR_GAP  = 4;
    localparam int RD_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_start = 1'b0, cmd_upload = 1'b0;
    logic [7:0]  cmd_index = '0;
    logic [15:0] cmd_length = '0;
    logic        busy, done, snk_wr, ioctl_download, ioctl_upload, ioctl_wr;
    logic [15:0] src_addr, snk_addr;
    logic [7:0]  src_data, snk_data, ioctl_index, ioctl_dout, ioctl_din;
    logic [24:0] ioctl_addr;
    logic [7:0]  p0, p1, p2;

    typedef struct { logic [24:0] a; logic [7:0] d; } ent_t;
    ent_t dq[$];
    ent_t uq[$];
    ent_t mon_e;

    int total = 0, bad = 0, cyc = 0;
    int wr_cnt = 0, snk_cnt = 0, strb_cnt = 0, done_cnt = 0, last_wr = -1, last_snk = -1, c0 = 0;
    logic [7:0]  exp_idx = '0;
    logic        prev_wr = 1'b0, prev_strb = 1'b0;
    logic [24:0] prev_addr = '0;
    logic [7:0]  prev_dout = '0;

    hs_ioctl_master #(.ADDR_WIDTH(25), .LEN_WIDTH(16), .SETUP_CYCLES(SETUP), .WR_GAP(WR_GAP), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_upload(cmd_upload), .cmd_index(cmd_index),
        .cmd_length(cmd_length), .busy(busy), .done(done), .src_addr(src_addr), .src_data(src_data),
        .snk_wr(snk_wr), .snk_addr(snk_addr), .snk_data(snk_data), .ioctl_download(ioctl_download),
        .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        src_data <= src_addr[7:0];
        p0 <= ioctl_addr[7:0] ^ 8'hA5;
        p1 <= p0;
        p2 <= p1;
    end
    assign ioctl_din = p2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ioctl_wr === 1'b1) begin
            wr_cnt++;
            check("wr_consec", prev_wr, 0);
            check("wr_pre_addr", prev_addr, ioctl_addr);
            check("wr_pre_dout", prev_dout, ioctl_dout);
            if (last_wr >= 0) check("wr_spacing", cyc - last_wr, 3 + WR_GAP);
            last_wr = cyc;
            if (dq.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                mon_e = dq.pop_front();
                check("wr_addr", ioctl_addr, mon_e.a);
                check("wr_dout", ioctl_dout, mon_e.d);
            end
        end
        if (snk_wr === 1'b1) begin
            snk_cnt++;
            if (last_snk >= 0) check("snk_spacing", cyc - last_snk, RD_WAIT + 2);
            last_snk = cyc;
            if (uq.size() == 0) check("snk_unexpected", 1, 0);
            else begin
                mon_e = uq.pop_front();
                check("snk_addr", snk_addr, 16'(mon_e.a));
                check("snk_data", snk_data, mon_e.d);
            end
        end
        if (done === 1'b1) done_cnt++;
        if (ioctl_download === 1'b1 || ioctl_upload === 1'b1) strb_cnt++;
        if (prev_strb && !(ioctl_download || ioctl_upload)) check("idx_fall", ioctl_index, exp_idx);
        prev_wr   = ioctl_wr;
        prev_strb = ioctl_download | ioctl_upload;
        prev_addr = ioctl_addr;
        prev_dout = ioctl_dout;
    end

    // latency is measured between the edge sampling cmd_start and the edge sampling done
    task automatic run(input logic up, input logic [7:0] idx, input int len, input bit poke);
        int per, exp_lat, lat, lim;
        bit got;
        per     = up ? RD_WAIT + 2 : 3 + WR_GAP;
        exp_lat = 1 + 2 * SETUP + len * per + 1;
        for (int n = 0; n < len; n++) begin
            if (up) uq.push_back('{25'(n), 8'(n) ^ 8'hA5});
            else dq.push_back('{25'(n), 8'(n)});
        end
        exp_idx = idx; wr_cnt = 0; snk_cnt = 0; strb_cnt = 0; last_wr = -1; last_snk = -1;
        @(negedge clk);
        cmd_start = 1'b1; cmd_upload = up; cmd_index = idx; cmd_length = 16'(len);
        @(posedge clk); #1;
        c0 = cyc;
        cmd_start = 1'b0;
        if (poke) begin cmd_index = 8'd9; cmd_upload = 1'b1; cmd_length = 16'd7; end
        check("busy_go", busy, 1);
        check("strobe_go", up ? ioctl_upload : ioctl_download, 1);
        got = 0; lat = 0; lim = exp_lat + 20;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            if (done) begin got = 1; lat = cyc + 1 - c0; end
            cmd_start = poke && (busy || done);
        end
        @(negedge clk);
        cmd_start = 1'b0;
        check("done_seen", got, 1);
        check("latency", lat, exp_lat);
        check("wr_count", wr_cnt, up ? 0 : len);
        check("snk_count", snk_cnt, up ? len : 0);
        check("strobe_cycles", strb_cnt, 2 * SETUP + len * per);
        check("queue_left", dq.size() + uq.size(), 0);
        check("busy_after", busy, 0);
        if (poke) begin
            repeat (10) @(negedge clk);
            check("no_restart", {busy, ioctl_download, ioctl_upload}, 0);
            check("idx_hold", ioctl_index, idx);
        end
    endtask

    initial begin
        bit found;
        int dc;
        repeat (3) @(negedge clk);
        check("rst_ctl", {busy, done, src_addr, snk_wr, snk_addr, snk_data}, 0);
        check("rst_ioctl", {ioctl_download, ioctl_upload, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(1'b0, 8'd3, 16, 1'b0);
        repeat (3) @(negedge clk);
        run(1'b1, 8'd4, 5, 1'b0);
        repeat (3) @(negedge clk);
        run(1'b0, 8'd3, 0, 1'b0);
        repeat (3) @(negedge clk);

        // abort a 10-byte download while byte 2 is on the bus
        for (int n = 0; n < 10; n++) dq.push_back('{25'(n), 8'(n)});
        exp_idx = 8'd3; last_wr = -1;
        @(negedge clk);
        cmd_start = 1'b1; cmd_upload = 1'b0; cmd_index = 8'd3; cmd_length = 16'd10;
        @(negedge clk);
        cmd_start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ioctl_addr == 25'd2 && ioctl_download) found = 1;
        end
        check("reach_byte2", found, 1);
        exp_idx = 8'd0;
        dc = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_ctl", {busy, done, src_addr, snk_wr, snk_addr, snk_data}, 0);
        check("mid_rst_ioctl", {ioctl_download, ioctl_upload, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout}, 0);
        reset = 1'b0;
        dq.delete();
        repeat (20) @(negedge clk);
        check("no_done_after_rst", done_cnt - dc, 0);
        run(1'b0, 8'd3, 10, 1'b0);
        repeat (3) @(negedge clk);

        run(1'b0, 8'd3, 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
